// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider.
// Accepts a dividend/divisor pair on an accepted start and produces one
// quotient bit per clock. It returns quotient and remainder together with a
// single-cycle done pulse. A zero divisor finishes after one cycle with
// q = all ones, r = dividend and div_zero set.
module seq_divider #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend shifts out, quotient bits shift in
  logic [WIDTH-1:0] b_q, b_d;       // latched divisor
  logic [CW-1:0]    cnt_q, cnt_d;   // iterations left
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   shifted;        // {rem, next dividend bit}
  logic [WIDTH+1:0] trial;          // shifted - b, MSB is the borrow
  logic             qbit;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] dvd_next;

  // One restoring step: shift, trial-subtract, keep the difference if no borrow.
  always_comb begin
    shifted  = {rem_q, dvd_q[WIDTH-1]};
    trial    = {1'b0, shifted} - {2'b00, b_q};
    qbit     = ~trial[WIDTH+1];
    rem_next = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    dvd_next = {dvd_q[WIDTH-2:0], qbit};
  end

  // Next-state and output computation for the IDLE/CALC controller.
  always_comb begin
    // NOTE: every signal gets a default here so that no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = dz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          b_d     = b;
          dvd_d   = a;
          rem_d   = '0;
          cnt_d   = CW'(WIDTH);
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        if (b_q == '0) begin
          // Divide by zero: report all-ones quotient and the dividend as remainder.
          q_d     = '1;
          r_d     = dvd_q;
          dz_d    = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          rem_d = rem_next;
          dvd_d = dvd_next;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            q_d     = dvd_next;
            r_d     = rem_next;
            dz_d    = 1'b0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset discards any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register, working state included, is cleared on reset, so
    // no stale operand or partial remainder survives an abort.
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      dvd_q   <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let all flops update from the same
      // pre-edge values, with no ordering dependence between them.
      state_q <= state_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign q        = q_q;
  assign r        = r_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider. A cycle-level behavioural model
// predicts busy, done, q, r and div_zero from plain division and a latency
// count. A compare process checks the DUT against the model every cycle.
// The directed cases also carry hand-computed expectations.
module tb_seq_divider;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] q, r;
  logic         busy, done, div_zero;

  int checks = 0;
  int failures = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .q        (q),
    .r        (r),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model. An operation accepted at edge e completes at edge
  // e+W, or at edge e+1 when the divisor is zero. Until then, start is ignored.
  int           m_cyc, m_done_at;
  logic [W-1:0] m_q, m_r, p_q, p_r;
  logic         m_dz, p_dz, m_done, m_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc = 0; m_done_at = 0;
      m_q = '0; m_r = '0; m_dz = 1'b0; m_done = 1'b0; m_busy = 1'b0;
      p_q = '0; p_r = '0; p_dz = 1'b0;
    end else begin
      m_cyc++;
      m_done = (m_cyc == m_done_at);
      if (m_done) begin
        m_q = p_q; m_r = p_r; m_dz = p_dz;
      end
      if (start && m_cyc > m_done_at) begin
        if (b == '0) begin
          p_q = '1; p_r = a; p_dz = 1'b1; m_done_at = m_cyc + 1;
        end else begin
          p_q = a / b; p_r = a % b; p_dz = 1'b0; m_done_at = m_cyc + W;
        end
      end
      m_busy = (m_done_at > m_cyc);
    end
  end

  // Compare the DUT against the model every cycle, away from the rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("q", q, m_q);
      check("r", r, m_r);
      if (m_done) check("div_zero", div_zero, m_dz);
    end
  end

  // Called at a negedge. Presents one start strobe and returns one negedge later.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    start = 1'b1; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts cycles after the accepting edge until done is seen.
  // An optional stray start is driven at cycle 2 and held for one cycle.
  task automatic wait_done(input bit noise, input logic [W-1:0] na, input logic [W-1:0] nb,
                           output int lat);
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (noise && lat == 2) begin
        start = 1'b1; a = na; b = nb;
      end else if (noise && lat == 3) begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input int eq, input int er, input int edz, input int elat);
    int lat;
    start_op(av, bv);
    wait_done(1'b0, '0, '0, lat);
    check("latency", lat, elat);
    check("q_lit", q, eq);
    check("r_lit", r, er);
    check("dz_lit", div_zero, edz);
    check("busy_at_done", busy, 0);
  endtask

  int order[4096];

  initial begin
    int lat;
    // Reset state.
    #1;
    @(negedge clk);
    check("rst_q", q, 0);
    check("rst_r", r, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz", div_zero, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Basic operation, and the result holding after done.
    run_op(6'd42, 6'd5, 8, 2, 0, 6);
    repeat (10) @(negedge clk);
    check("hold_q", q, 8);
    check("hold_r", r, 2);

    run_op(6'd4, 6'd10, 0, 4, 0, 6);
    run_op(6'd63, 6'd1, 63, 0, 0, 6);
    run_op(6'd63, 6'd63, 1, 0, 0, 6);

    // Zero divisor: busy for one cycle, done on the next edge.
    start_op(6'd7, 6'd0);
    check("dz_busy", busy, 1);
    wait_done(1'b0, '0, '0, lat);
    check("dz_latency", lat, 1);
    check("dz_q", q, 63);
    check("dz_r", r, 7);
    check("dz_flag", div_zero, 1);
    check("dz_busy_end", busy, 0);

    // A start while busy is ignored. A start in the done cycle is accepted.
    start_op(6'd42, 6'd5);
    wait_done(1'b1, 6'd9, 6'd3, lat);
    check("ign_latency", lat, 6);
    check("ign_q", q, 8);
    check("ign_r", r, 2);
    run_op(6'd9, 6'd3, 3, 0, 0, 6);

    // Asynchronous reset in the middle of an operation.
    start_op(6'd50, 6'd7);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_q", q, 0);
    check("abort_r", r, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_dz", div_zero, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    run_op(6'd50, 6'd7, 7, 1, 0, 6);

    // Sweep every (a, b) pair with b != 0 in shuffled order, back to back,
    // with occasional stray starts while busy.
    for (int i = 0; i < 4096; i++) order[i] = i;
    for (int i = 4095; i > 0; i--) begin
      int j, t;
      j = $urandom_range(0, i);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int i = 0; i < 4096; i++) begin
      logic [W-1:0] av, bv;
      av = order[i][11:6];
      bv = order[i][5:0];
      if (bv != '0) begin
        start_op(av, bv);
        wait_done($urandom_range(0, 3) == 0, W'($urandom), W'($urandom), lat);
        check("recon", int'(q) * int'(bv) + int'(r), int'(av));
        check("r_lt_b", r < bv, 1);
      end
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
